// File: rtl/weight_router_mc_if.sv
// Host, load-control and PE-lane signals of the multi-lane weight router.
// The host/DMA side drives through master; the router uses slave.
interface weight_router_mc_if #(
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CH          = 4,
  parameter int DEPTH           = 32
) ();
  localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FA     = $clog2(DEPTH);

  logic                         i_clear;
  logic                         i_spad_write_en;
  logic [ADDR_WIDTH-1:0]        i_write_addr;
  logic [SPAD_DATA_WIDTH-1:0]   i_data_in;
  logic                         i_load_start;
  logic [LANE_W-1:0]            i_load_lane;
  logic                         i_load_broadcast;
  logic [ADDR_WIDTH-1:0]        i_start_addr;
  logic [ADDR_WIDTH-1:0]        i_word_count;
  logic                         o_load_busy;
  logic                         o_load_done;
  logic                         o_overflow;
  logic                         i_swap;
  logic [FA:0]                  i_route_size;
  logic [7:0]                   i_reuse_count;
  logic [NUM_CH-1:0]            i_pop_en;
  logic [NUM_CH*DATA_WIDTH-1:0] o_data;
  logic [NUM_CH-1:0]            o_data_valid;
  logic [NUM_CH-1:0]            o_lane_done;

  modport master (
    output i_clear, i_spad_write_en, i_write_addr, i_data_in,
    output i_load_start, i_load_lane, i_load_broadcast,
    output i_start_addr, i_word_count, i_swap,
    output i_route_size, i_reuse_count, i_pop_en,
    input  o_load_busy, o_load_done, o_overflow,
    input  o_data, o_data_valid, o_lane_done
  );

  modport slave (
    input  i_clear, i_spad_write_en, i_write_addr, i_data_in,
    input  i_load_start, i_load_lane, i_load_broadcast,
    input  i_start_addr, i_word_count, i_swap,
    input  i_route_size, i_reuse_count, i_pop_en,
    output o_load_busy, o_load_done, o_overflow,
    output o_data, o_data_valid, o_lane_done
  );
endinterface

// File: rtl/weight_router_mc.sv
// Weight scratchpad plus per-lane ping-pong element banks; the back
// bank is loaded from the scratchpad while the front bank streams.
module weight_router_mc #(
  parameter int SPAD_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_CH          = 4,
  parameter int DEPTH           = 32
) (
  input logic               i_clk,
  input logic               i_rst,
  weight_router_mc_if.slave bus
);
  localparam int ELEMS = SPAD_DATA_WIDTH / DATA_WIDTH;
  localparam int FA    = $clog2(DEPTH);
  localparam int IW    = ADDR_WIDTH + $clog2(ELEMS) + 1;
  localparam logic [FA:0] RP_ONE = (FA+1)'(1);
  localparam logic [FA:0] S_MAX  = (FA+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  logic [SPAD_DATA_WIDTH-1:0] spad [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]      bank [NUM_CH][2][DEPTH];

  state_t                     state;
  logic [SPAD_DATA_WIDTH-1:0] rd_word;
  logic                       rd_vld;
  logic [ADDR_WIDTH-1:0]      rd_addr;
  logic [ADDR_WIDTH-1:0]      rem;
  logic [ADDR_WIDTH-1:0]      wr_word;
  logic [NUM_CH-1:0]          mask;
  logic                       sel;
  logic                       busy;
  logic                       done_p;
  logic                       ovf;

  logic                       kill;
  logic                       swap_ok;
  logic                       back;
  logic [IW-1:0]              base;
  logic [IW-1:0]              eidx [ELEMS];
  logic                       word_ovf;
  logic [FA:0]                s_eff;

  logic [FA:0]                rp    [NUM_CH];
  logic [7:0]                 pass  [NUM_CH];
  logic [DATA_WIDTH-1:0]      dat   [NUM_CH];
  logic [NUM_CH-1:0]          vld;
  logic [NUM_CH-1:0]          ldone;

  assign kill    = i_rst | bus.i_clear;
  assign swap_ok = bus.i_swap && (state == IDLE);
  assign back    = ~sel;
  assign s_eff   = (bus.i_route_size > S_MAX) ? S_MAX : bus.i_route_size;

  always_comb begin
    base = IW'(wr_word) * IW'(ELEMS);
    for (int j = 0; j < ELEMS; j++) begin
      eidx[j] = base + IW'(j);
    end
    word_ovf = (eidx[ELEMS-1] >= IW'(DEPTH));
  end

  // Scratchpad: registered read, so a colliding write shows up next time.
  always_ff @(posedge i_clk) begin
    if (bus.i_spad_write_en) begin
      spad[bus.i_write_addr] <= bus.i_data_in;
    end
    if (state == READ) begin
      rd_word <= spad[rd_addr];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!kill && rd_vld) begin
      for (int l = 0; l < NUM_CH; l++) begin
        for (int j = 0; j < ELEMS; j++) begin
          if (mask[l] && (eidx[j] < IW'(DEPTH))) begin
            bank[l][back][eidx[j][FA-1:0]] <=
              rd_word[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (kill) begin
      state   <= IDLE;
      rd_vld  <= 1'b0;
      rd_addr <= '0;
      rem     <= '0;
      wr_word <= '0;
      mask    <= '0;
      sel     <= 1'b0;
      busy    <= 1'b0;
      done_p  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done_p <= 1'b0;
      rd_vld <= (state == READ);
      if (swap_ok) begin
        sel <= ~sel;
      end
      if (rd_vld) begin
        wr_word <= wr_word + ADDR_WIDTH'(1);
        if (word_ovf) begin
          ovf <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (bus.i_load_start) begin
            if (bus.i_word_count == '0) begin
              done_p <= 1'b1;
            end else begin
              state   <= READ;
              busy    <= 1'b1;
              rd_addr <= bus.i_start_addr;
              rem     <= bus.i_word_count;
              wr_word <= '0;
              mask    <= bus.i_load_broadcast ? '1 :
                         (NUM_CH'(1) << bus.i_load_lane);
            end
          end
        end
        READ: begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
          rem     <= rem - ADDR_WIDTH'(1);
          if (rem == ADDR_WIDTH'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy   <= 1'b0;
          done_p <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane stream; a swap restarts every lane on the new front bank.
  always_ff @(posedge i_clk) begin
    if (kill) begin
      vld   <= '0;
      ldone <= '0;
      for (int l = 0; l < NUM_CH; l++) begin
        rp[l]   <= '0;
        pass[l] <= '0;
        dat[l]  <= '0;
      end
    end else begin
      for (int l = 0; l < NUM_CH; l++) begin
        vld[l] <= 1'b0;
        if (swap_ok) begin
          rp[l]    <= '0;
          pass[l]  <= '0;
          ldone[l] <= 1'b0;
        end else if (!ldone[l]) begin
          if (s_eff == '0) begin
            ldone[l] <= 1'b1;
          end else if (bus.i_pop_en[l]) begin
            vld[l] <= 1'b1;
            dat[l] <= bank[l][sel][rp[l][FA-1:0]];
            if (rp[l] == s_eff - RP_ONE) begin
              if (pass[l] < bus.i_reuse_count) begin
                rp[l]   <= '0;
                pass[l] <= pass[l] + 8'd1;
              end else begin
                ldone[l] <= 1'b1;
              end
            end else begin
              rp[l] <= rp[l] + RP_ONE;
            end
          end
        end
      end
    end
  end

  always_comb begin
    bus.o_data = '0;
    for (int l = 0; l < NUM_CH; l++) begin
      bus.o_data[l*DATA_WIDTH +: DATA_WIDTH] = dat[l];
    end
  end

  assign bus.o_data_valid = vld;
  assign bus.o_lane_done  = ldone;
  assign bus.o_load_busy  = busy;
  assign bus.o_load_done  = done_p;
  assign bus.o_overflow   = ovf;
endmodule

// File: tb/tb_weight_router_mc.sv
// Directed bench for weight_router_mc: expected lane elements go to
// per-lane queues, a negedge monitor pops and compares every valid.
module tb_weight_router_mc;
  typedef struct {
    logic [7:0] d;
    bit         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [4][$];

  always #5 clk = ~clk;

  weight_router_mc_if bus ();

  weight_router_mc dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int l, input logic [7:0] d, input bit last);
    exp_t e;
    e.d    = d;
    e.last = last;
    sb[l].push_back(e);
  endtask

  task automatic spad_wr(input logic [7:0] a, input logic [63:0] d);
    bus.i_spad_write_en = 1'b1;
    bus.i_write_addr    = a;
    bus.i_data_in       = d;
    tick();
    bus.i_spad_write_en = 1'b0;
  endtask

  task automatic do_swap();
    bus.i_swap = 1'b1;
    tick();
    bus.i_swap = 1'b0;
  endtask

  task automatic pops(input logic [3:0] m, input int n);
    bus.i_pop_en = m;
    repeat (n) tick();
    bus.i_pop_en = '0;
    repeat (2) tick();
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      if (bus.o_load_done) seen = 1'b1;
      else tick();
    end
    chk(name, 64'(seen), 64'd1);
    tick();
  endtask

  task automatic load_wait(input logic [7:0] a, input logic [7:0] n,
                           input logic [1:0] lane, input bit bc,
                           input string name);
    bus.i_load_start     = 1'b1;
    bus.i_start_addr     = a;
    bus.i_word_count     = n;
    bus.i_load_lane      = lane;
    bus.i_load_broadcast = bc;
    tick();
    bus.i_load_start = 1'b0;
    wait_done(name);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int l = 0; l < 4; l++) begin
        if (bus.o_data_valid[l]) begin
          checks++;
          if (sb[l].size() == 0) begin
            errors++;
            $display("FAIL lane%0d_unexpected actual=%h required=none",
                     l, bus.o_data[l*8 +: 8]);
          end else begin
            e = sb[l].pop_front();
            if (bus.o_data[l*8 +: 8] !== e.d ||
                bus.o_lane_done[l] !== e.last) begin
              errors++;
              $display("FAIL lane%0d_elem actual=%h/%b required=%h/%b",
                       l, bus.o_data[l*8 +: 8], bus.o_lane_done[l],
                       e.d, e.last);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] w;
    bit          seen;
    bus.i_clear          = 1'b0;
    bus.i_spad_write_en  = 1'b0;
    bus.i_write_addr     = '0;
    bus.i_data_in        = '0;
    bus.i_load_start     = 1'b0;
    bus.i_load_lane      = '0;
    bus.i_load_broadcast = 1'b0;
    bus.i_start_addr     = '0;
    bus.i_word_count     = '0;
    bus.i_swap           = 1'b0;
    bus.i_route_size     = 6'd8;
    bus.i_reuse_count    = 8'd0;
    bus.i_pop_en         = '0;
    repeat (3) tick();
    chk("rst_data", 64'(bus.o_data), 64'd0);
    chk("rst_valid", 64'(bus.o_data_valid), 64'd0);
    chk("rst_lane_done", 64'(bus.o_lane_done), 64'd0);
    chk("rst_busy", 64'(bus.o_load_busy), 64'd0);
    chk("rst_load_done", 64'(bus.o_load_done), 64'd0);
    chk("rst_overflow", 64'(bus.o_overflow), 64'd0);
    rst = 1'b0;
    tick();

    // broadcast load, exact load timing
    spad_wr(8'd5, 64'h0807060504030201);
    bus.i_load_start     = 1'b1;
    bus.i_start_addr     = 8'd5;
    bus.i_word_count     = 8'd1;
    bus.i_load_broadcast = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
    chk("t1_busy_c1", 64'(bus.o_load_busy), 64'd1);
    chk("t1_done_c1", 64'(bus.o_load_done), 64'd0);
    tick();
    chk("t1_busy_c2", 64'(bus.o_load_busy), 64'd1);
    chk("t1_done_c2", 64'(bus.o_load_done), 64'd0);
    tick();
    chk("t1_busy_c3", 64'(bus.o_load_busy), 64'd0);
    chk("t1_done_c3", 64'(bus.o_load_done), 64'd1);
    tick();
    chk("t1_done_c4", 64'(bus.o_load_done), 64'd0);
    do_swap();
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 8; i++) push(l, 8'(i + 1), i == 7);
    pops(4'hF, 8);

    // ping-pong: stream lane 0 while its back bank reloads
    spad_wr(8'd8, 64'h3837363534333231);
    spad_wr(8'd10, 64'h1817161514131211);
    load_wait(8'd8, 8'd1, 2'd0, 1'b1, "t2_bank0_done");
    do_swap();
    bus.i_reuse_count = 8'd3;
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 8; i++) push(0, 8'(8'h31 + i), p == 3 && i == 7);
    fork
      pops(4'b0001, 32);
      begin
        repeat (3) tick();
        bus.i_load_start     = 1'b1;
        bus.i_start_addr     = 8'd10;
        bus.i_word_count     = 8'd1;
        bus.i_load_lane      = 2'd0;
        bus.i_load_broadcast = 1'b0;
        tick();
        bus.i_load_start = 1'b0;
        chk("t2_busy", 64'(bus.o_load_busy), 64'd1);
        bus.i_swap = 1'b1;
        tick();
        bus.i_swap = 1'b0;
        wait_done("t2_load_done");
      end
    join
    bus.i_reuse_count = 8'd0;
    do_swap();
    for (int i = 0; i < 8; i++) push(0, 8'(8'h11 + i), i == 7);
    pops(4'b0001, 8);

    // reuse: S=4, two extra passes, 13th pop must be dropped
    bus.i_route_size  = 6'd4;
    bus.i_reuse_count = 8'd2;
    do_swap();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) push(1, 8'(8'h31 + i), p == 2 && i == 3);
    pops(4'b0010, 13);

    // lane independence and overflow
    chk("t4_ovf_before", 64'(bus.o_overflow), 64'd0);
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'h80 + 8*k + j);
      spad_wr(8'(20 + k), w);
    end
    load_wait(8'd20, 8'd5, 2'd2, 1'b0, "t4_load_done");
    chk("t4_ovf_after", 64'(bus.o_overflow), 64'd1);
    bus.i_route_size  = 6'd32;
    bus.i_reuse_count = 8'd0;
    do_swap();
    for (int i = 0; i < 32; i++) push(2, 8'(8'h80 + i), i == 31);
    pops(4'b0100, 32);
    chk("t4_lane_done", 64'(bus.o_lane_done), 64'h4);

    // S = 0: done the cycle after swap, pops ignored
    bus.i_route_size = 6'd0;
    do_swap();
    chk("s0_done_swap_cycle", 64'(bus.o_lane_done), 64'h0);
    tick();
    chk("s0_done_next", 64'(bus.o_lane_done), 64'hF);
    pops(4'hF, 3);

    // zero word count
    bus.i_load_start = 1'b1;
    bus.i_word_count = 8'd0;
    tick();
    bus.i_load_start = 1'b0;
    chk("wc0_done", 64'(bus.o_load_done), 64'd1);
    chk("wc0_busy", 64'(bus.o_load_busy), 64'd0);
    tick();
    chk("wc0_done_low", 64'(bus.o_load_done), 64'd0);

    // address wrap 0xFE, 0xFF, 0x00
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 8; j++) w[j*8 +: 8] = 8'(8'hC0 + 8*k + j);
      spad_wr(8'(8'hFE + k), w);
    end
    load_wait(8'hFE, 8'd3, 2'd3, 1'b0, "wrap_load_done");
    bus.i_route_size = 6'd24;
    do_swap();
    for (int i = 0; i < 24; i++) push(3, 8'(8'hC0 + i), i == 23);
    pops(4'b1000, 24);

    // reset mid-load
    bus.i_load_start = 1'b1;
    bus.i_start_addr = 8'd0;
    bus.i_word_count = 8'd5;
    bus.i_load_lane  = 2'd0;
    tick();
    bus.i_load_start = 1'b0;
    tick();
    chk("rstmid_busy_before", 64'(bus.o_load_busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 64'(bus.o_load_busy), 64'd0);
    chk("rstmid_ovf", 64'(bus.o_overflow), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.o_load_done) seen = 1'b1;
      tick();
    end
    chk("rstmid_no_done", 64'(seen), 64'd0);

    repeat (3) tick();
    for (int l = 0; l < 4; l++) chk($sformatf("sb_empty_lane%0d", l),
                                    64'(sb[l].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
